// File: rtl/shift_ser.sv
// shift_ser: parallel-load, bit-strobed serializer with back-to-back reload.
// Ports: clk, rst (sync active-low), D/load_valid/load_ready load handshake,
//        shift_en bit strobe, Q serial out, busy in-flight flag, eos pulse.
module shift_ser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter bit IDLE_LVL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             Q,
    output logic             busy,
    output logic             eos
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [CW-1:0]    nxt;
    logic [CW-1:0]    idx;
    logic             q_n;
    logic             busy_n;
    logic             eos_n;
    logic             word_end;
    logic             load;
    logic             first_bit;
    logic             next_bit;

    // Last bit is being consumed on this edge.
    assign word_end = (state == SHIFT) && shift_en && (cnt == LAST);
    assign load     = load_valid && load_ready;

    // Position of the bit that follows the current one in shift order.
    assign nxt       = cnt + CW'(1);
    assign idx       = MSB_FIRST ? (LAST - nxt) : nxt;
    assign next_bit  = shadow[idx];
    assign first_bit = MSB_FIRST ? D[WIDTH-1] : D[0];

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
            Q      <= IDLE_LVL;
            busy   <= 1'b0;
            eos    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            shadow <= shadow_n;
            Q      <= q_n;
            busy   <= busy_n;
            eos    <= eos_n;
        end
    end

    // Next-state logic; a load at word end wins over the return to IDLE.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shadow_n = shadow;
        q_n      = Q;
        busy_n   = busy;
        eos_n    = word_end;
        if (load) begin
            state_n  = SHIFT;
            cnt_n    = '0;
            shadow_n = D;
            q_n      = first_bit;
            busy_n   = 1'b1;
        end else if (word_end) begin
            state_n = IDLE;
            cnt_n   = '0;
            q_n     = IDLE_LVL;
            busy_n  = 1'b0;
        end else if (state == SHIFT && shift_en) begin
            cnt_n = nxt;
            q_n   = next_bit;
        end
    end

    // Output logic
    always_comb begin
        load_ready = 1'b0;
        if (rst) begin
            load_ready = (state == IDLE) || word_end;
        end
    end

endmodule

// File: tb/tb_shift_ser.sv
// tb_shift_ser: scoreboard bench for shift_ser across four parameter sets.
// Expected serial bits are queued at load time and popped as Q presents them.
module tb_shift_ser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];

    // a: WIDTH=8, LSB first
    logic       a_rst, a_lv, a_se, a_lr, a_q, a_busy, a_eos;
    logic [7:0] a_d;
    // b: WIDTH=8, MSB first
    logic       b_rst, b_lv, b_se, b_lr, b_q, b_busy, b_eos;
    logic [7:0] b_d;
    // c: WIDTH=4, LSB first
    logic       c_rst, c_lv, c_se, c_lr, c_q, c_busy, c_eos;
    logic [3:0] c_d;
    // u: WIDTH=1, idle level 1
    logic       u_rst, u_lv, u_se, u_lr, u_q, u_busy, u_eos;
    logic [0:0] u_d;

    shift_ser #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) dut_a (
        .clk(clk), .rst(a_rst), .D(a_d), .load_valid(a_lv),
        .load_ready(a_lr), .shift_en(a_se), .Q(a_q),
        .busy(a_busy), .eos(a_eos)
    );

    shift_ser #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) dut_b (
        .clk(clk), .rst(b_rst), .D(b_d), .load_valid(b_lv),
        .load_ready(b_lr), .shift_en(b_se), .Q(b_q),
        .busy(b_busy), .eos(b_eos)
    );

    shift_ser #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) dut_c (
        .clk(clk), .rst(c_rst), .D(c_d), .load_valid(c_lv),
        .load_ready(c_lr), .shift_en(c_se), .Q(c_q),
        .busy(c_busy), .eos(c_eos)
    );

    shift_ser #(.WIDTH(1), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) dut_u (
        .clk(clk), .rst(u_rst), .D(u_d), .load_valid(u_lv),
        .load_ready(u_lr), .shift_en(u_se), .Q(u_q),
        .busy(u_busy), .eos(u_eos)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_lv = 1'b1;
        a_d  = 8'hFF;
        a_se = 1'b1;
        step();
        step();
        #1;
        checks++;
        if ({a_q, a_busy, a_eos, a_lr} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_a: got %b expected 0000",
                     {a_q, a_busy, a_eos, a_lr});
        end
        checks++;
        if ({b_q, b_busy, b_eos, b_lr} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_b: got %b expected 0000",
                     {b_q, b_busy, b_eos, b_lr});
        end
        checks++;
        if ({c_q, c_busy, c_eos, c_lr} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_c: got %b expected 0000",
                     {c_q, c_busy, c_eos, c_lr});
        end
        checks++;
        if ({u_q, u_busy, u_eos, u_lr} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_u: got %b expected 1000",
                     {u_q, u_busy, u_eos, u_lr});
        end
        a_lv  = 1'b0;
        a_se  = 1'b0;
        a_rst = 1'b1;
        b_rst = 1'b1;
        c_rst = 1'b1;
        u_rst = 1'b1;
        #1;
        checks++;
        if (a_lr !== 1'b1) begin
            errors++;
            $display("FAIL ready_idle: got %b expected 1", a_lr);
        end
        step();
    endtask

    task automatic test_lsb_single();
        bit e;
        a_d  = 8'hA5;
        a_lv = 1'b1;
        a_se = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(a_d[i]);
        #1;
        checks++;
        if (a_lr !== 1'b1) begin
            errors++;
            $display("FAIL lsb_ready: got %b expected 1", a_lr);
        end
        step();
        a_lv = 1'b0;
        a_d  = 8'h00;
        for (int c = 0; c < 8; c++) begin
            e = exp_q.pop_front();
            checks++;
            if ({a_q, a_busy, a_eos} !== {e, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL lsb_bit%0d: got %b expected %b", c,
                         {a_q, a_busy, a_eos}, {e, 1'b1, 1'b0});
            end
            step();
        end
        checks++;
        if ({a_q, a_busy, a_eos} !== 3'b001) begin
            errors++;
            $display("FAIL lsb_end: got %b expected 001",
                     {a_q, a_busy, a_eos});
        end
        step();
        checks++;
        if ({a_q, a_busy, a_eos} !== 3'b000) begin
            errors++;
            $display("FAIL lsb_after: got %b expected 000",
                     {a_q, a_busy, a_eos});
        end
        a_se = 1'b0;
    endtask

    task automatic test_msb_b2b();
        bit         e;
        bit         ee;
        bit         er;
        logic [7:0] nw;
        nw   = 8'h3C;
        b_d  = 8'hA5;
        b_lv = 1'b1;
        b_se = 1'b1;
        for (int i = 7; i >= 0; i--) exp_q.push_back(b_d[i]);
        for (int i = 7; i >= 0; i--) exp_q.push_back(nw[i]);
        step();
        b_d = nw;
        for (int c = 0; c < 16; c++) begin
            e  = exp_q.pop_front();
            ee = (c == 8);
            er = (c == 7) || (c == 15);
            checks++;
            if ({b_q, b_busy, b_eos} !== {e, 1'b1, ee}) begin
                errors++;
                $display("FAIL msb_bit%0d: got %b expected %b", c,
                         {b_q, b_busy, b_eos}, {e, 1'b1, ee});
            end
            checks++;
            if (b_lr !== er) begin
                errors++;
                $display("FAIL msb_ready%0d: got %b expected %b",
                         c, b_lr, er);
            end
            if (c == 8) b_lv = 1'b0;
            step();
        end
        checks++;
        if ({b_q, b_busy, b_eos} !== 3'b001) begin
            errors++;
            $display("FAIL msb_end: got %b expected 001",
                     {b_q, b_busy, b_eos});
        end
        step();
        checks++;
        if (b_eos !== 1'b0) begin
            errors++;
            $display("FAIL msb_after: got %b expected 0", b_eos);
        end
        b_se = 1'b0;
    endtask

    task automatic test_slow();
        bit cur;
        bit er;
        cur  = 1'b0;
        c_d  = 4'h6;
        c_lv = 1'b1;
        c_se = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(c_d[i]);
        #1;
        checks++;
        if (c_lr !== 1'b1) begin
            errors++;
            $display("FAIL slow_ready0: got %b expected 1", c_lr);
        end
        step();
        c_lv = 1'b0;
        for (int cy = 0; cy < 12; cy++) begin
            if (cy % 3 == 0) cur = exp_q.pop_front();
            c_se = (cy % 3 == 2);
            if (cy == 4) c_d = 4'hF;
            #1;
            er = (cy == 11);
            checks++;
            if ({c_q, c_busy, c_eos} !== {cur, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL slow_cy%0d: got %b expected %b", cy,
                         {c_q, c_busy, c_eos}, {cur, 1'b1, 1'b0});
            end
            checks++;
            if (c_lr !== er) begin
                errors++;
                $display("FAIL slow_ready%0d: got %b expected %b",
                         cy, c_lr, er);
            end
            step();
        end
        c_se = 1'b0;
        checks++;
        if ({c_q, c_busy, c_eos} !== 3'b001) begin
            errors++;
            $display("FAIL slow_end: got %b expected 001",
                     {c_q, c_busy, c_eos});
        end
        c_se = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({c_q, c_busy, c_eos} !== 3'b000) begin
                errors++;
                $display("FAIL idle_ignore%0d: got %b expected 000",
                         i, {c_q, c_busy, c_eos});
            end
        end
        c_se = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit e;
        a_d  = 8'hFF;
        a_lv = 1'b1;
        a_se = 1'b1;
        step();
        a_lv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({a_q, a_busy, a_eos} !== 3'b110) begin
                errors++;
                $display("FAIL mid_bit%0d: got %b expected 110", i,
                         {a_q, a_busy, a_eos});
            end
            if (i == 3) begin
                a_rst = 1'b0;
                a_lv  = 1'b1;
                a_d   = 8'h55;
                #1;
                checks++;
                if (a_lr !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_ready: got %b expected 0", a_lr);
                end
            end
            step();
        end
        checks++;
        if ({a_q, a_busy, a_eos} !== 3'b000) begin
            errors++;
            $display("FAIL mid_abort: got %b expected 000",
                     {a_q, a_busy, a_eos});
        end
        a_rst = 1'b1;
        a_lv  = 1'b0;
        step();
        checks++;
        if ({a_q, a_busy, a_eos} !== 3'b000) begin
            errors++;
            $display("FAIL mid_noeos: got %b expected 000",
                     {a_q, a_busy, a_eos});
        end
        a_d  = 8'h01;
        a_lv = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(a_d[i]);
        step();
        a_lv = 1'b0;
        for (int c = 0; c < 8; c++) begin
            e = exp_q.pop_front();
            checks++;
            if ({a_q, a_busy, a_eos} !== {e, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL post_bit%0d: got %b expected %b", c,
                         {a_q, a_busy, a_eos}, {e, 1'b1, 1'b0});
            end
            step();
        end
        checks++;
        if ({a_q, a_busy, a_eos} !== 3'b001) begin
            errors++;
            $display("FAIL post_end: got %b expected 001",
                     {a_q, a_busy, a_eos});
        end
        a_se = 1'b0;
    endtask

    task automatic test_width1();
        bit e;
        bit ee;
        bit vals[3];
        vals[0] = 1'b0;
        vals[1] = 1'b1;
        vals[2] = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(vals[i]);
        u_d  = vals[0];
        u_lv = 1'b1;
        u_se = 1'b1;
        #1;
        checks++;
        if (u_lr !== 1'b1) begin
            errors++;
            $display("FAIL w1_ready_idle: got %b expected 1", u_lr);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            e  = exp_q.pop_front();
            ee = (k != 0);
            checks++;
            if ({u_q, u_busy, u_eos} !== {e, 1'b1, ee}) begin
                errors++;
                $display("FAIL w1_bit%0d: got %b expected %b", k,
                         {u_q, u_busy, u_eos}, {e, 1'b1, ee});
            end
            checks++;
            if (u_lr !== 1'b1) begin
                errors++;
                $display("FAIL w1_ready%0d: got %b expected 1",
                         k, u_lr);
            end
            if (k < 2) u_d = vals[k+1];
            else u_lv = 1'b0;
            step();
        end
        checks++;
        if ({u_q, u_busy, u_eos} !== 3'b101) begin
            errors++;
            $display("FAIL w1_end: got %b expected 101",
                     {u_q, u_busy, u_eos});
        end
        u_se = 1'b0;
        step();
        checks++;
        if ({u_q, u_busy, u_eos} !== 3'b100) begin
            errors++;
            $display("FAIL w1_after: got %b expected 100",
                     {u_q, u_busy, u_eos});
        end
    endtask

    initial begin
        a_rst = 1'b0; a_lv = 1'b0; a_se = 1'b0; a_d = '0;
        b_rst = 1'b0; b_lv = 1'b0; b_se = 1'b0; b_d = '0;
        c_rst = 1'b0; c_lv = 1'b0; c_se = 1'b0; c_d = '0;
        u_rst = 1'b0; u_lv = 1'b0; u_se = 1'b0; u_d = '0;
        test_reset();
        test_lsb_single();
        test_msb_b2b();
        test_slow();
        test_reset_mid();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
